// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, default address map and lane helpers for mem_lsu
package lsu_pkg;
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } mem_size_e;
    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } sb_entry_t;
    localparam logic [31:0] DEF_DMEM_BASE  = 32'h1000_0000;
    localparam logic [31:0] DEF_UART_ADDR  = 32'hFFFF_0000;
    localparam logic [31:0] DEF_TIMER_ADDR = 32'hFFFF_FF00;
    function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] off);
        return size[1] ? 4'b1111 : size[0] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    endfunction
    function automatic logic [31:0] store_data(input logic [2:0] size, input logic [1:0] off,
                                               input logic [31:0] wdata);
        return size[1] ? wdata
             : size[0] ? (off[1] ? {wdata[15:0], 16'h0000} : {16'h0000, wdata[15:0]})
             : {24'h00_0000, wdata[7:0]} << {off, 3'b000};
    endfunction
    function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [15:0] h;
        logic [7:0]  b;
        h = off[1] ? word[31:16] : word[15:0];
        b = word[{off, 3'b000} +: 8];
        return size[1] ? word
             : size[0] ? {{16{h[15] & ~size[2]}}, h}
             : {{24{b[7] & ~size[2]}}, b};
    endfunction
endpackage

// File: rtl/lsu_store_buffer.sv
// lsu_store_buffer: in-order store FIFO with a parallel word-address hit and a drain port
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  sb_entry_t   push_entry,
    input  logic        pop,
    input  logic [29:0] match_addr,
    output sb_entry_t   head,
    output logic        empty,
    output logic        full,
    output logic        hit
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [AW:0] ONE = PW'(1);
    sb_entry_t   mem [DEPTH];
    logic [AW:0] rd_ptr, wr_ptr, count;
    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE;
            if (pop) rd_ptr <= rd_ptr + ONE;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end
    // only the live window [rd_ptr, wr_ptr) takes part in the hazard compare
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            hit = hit | ((PW'(i) < count) && (mem[AW'(rd_ptr + PW'(i))].addr == match_addr));
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with store buffer, MMIO decode and load lane extension
// Build option: LSU_MISALIGN_TRAP_EN accepts and drops misaligned H/W accesses, pulsing misalign
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int          SB_DEPTH   = 4,
    parameter logic [31:0] DMEM_BASE  = DEF_DMEM_BASE,
    parameter int          DMEM_AW    = 18,
    parameter logic [31:0] UART_ADDR  = DEF_UART_ADDR,
    parameter logic [31:0] TIMER_ADDR = DEF_TIMER_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_store,
    input  logic [2:0]         req_size,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               req_ready,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               misalign,
    output logic               dmem_we,
    output logic [3:0]         dmem_be,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    output logic               uart_valid,
    output logic [7:0]         uart_data,
    input  logic               uart_ready,
    input  logic [31:0]        timer_val
);
    typedef enum logic [1:0] {SRC_ZERO, SRC_DMEM, SRC_TIMER} src_e;
    logic [31:0]        off;
    logic [DMEM_AW-1:0] load_waddr;
    logic               is_dmem, is_uart, is_timer, mis;
    logic               dmem_load, load_acc, drain_now, accept, hit, sb_empty, sb_full;
    sb_entry_t          head, new_entry;
    mem_size_e          size_q;
    logic [1:0]         off_q;
    src_e               src_q;
    logic [31:0]        timer_q;
    logic               resp_q, mis_q;
    assign off        = req_addr - DMEM_BASE;
    assign is_dmem    = off[31:DMEM_AW] == '0;
    assign is_uart    = req_addr == UART_ADDR;
    assign is_timer   = req_addr == TIMER_ADDR;
    assign load_waddr = DMEM_AW'(off) & ~DMEM_AW'(3);
`ifdef LSU_MISALIGN_TRAP_EN
    assign mis = ((req_size == SZ_H || req_size == SZ_HU) && req_addr[0])
              || (req_size == SZ_W && req_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    // a load accepted this cycle owns the memory port; otherwise the head store drains
    assign dmem_load = req_valid && !req_store && is_dmem && !mis;
    assign load_acc  = dmem_load && !hit;
    assign drain_now = !sb_empty && !load_acc;
    assign req_ready = mis       ? 1'b1
                     : req_store ? (is_dmem ? (!sb_full || drain_now) : is_uart ? uart_ready : 1'b1)
                     : !(is_dmem && hit);
    assign accept    = req_valid && req_ready;
    assign new_entry = {off[31:2], store_be(req_size, req_addr[1:0]),
                        store_data(req_size, req_addr[1:0], req_wdata)};
    lsu_store_buffer #(.DEPTH(SB_DEPTH)) u_sb (
        .clk        (clk),
        .rst        (rst),
        .push       (accept && req_store && is_dmem && !mis),
        .push_entry (new_entry),
        .pop        (drain_now),
        .match_addr (off[31:2]),
        .head       (head),
        .empty      (sb_empty),
        .full       (sb_full),
        .hit        (hit)
    );
    assign dmem_we    = drain_now;
    assign dmem_be    = drain_now ? head.be : 4'b0000;
    assign dmem_wdata = drain_now ? head.data : 32'h0;
    assign dmem_addr  = drain_now ? DMEM_AW'({head.addr, 2'b00}) : dmem_load ? load_waddr : '0;
    assign uart_valid = accept && req_store && is_uart && !mis;
    assign uart_data  = uart_valid ? req_wdata[7:0] : 8'h00;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_q  <= 1'b0;
            mis_q   <= 1'b0;
            size_q  <= SZ_B;
            off_q   <= 2'b00;
            src_q   <= SRC_ZERO;
            timer_q <= 32'h0;
        end else begin
            resp_q <= accept && !req_store && !mis;
            mis_q  <= accept && mis;
            if (accept && !req_store) begin
                size_q  <= mem_size_e'(req_size);
                off_q   <= req_addr[1:0];
                src_q   <= is_dmem ? SRC_DMEM : is_timer ? SRC_TIMER : SRC_ZERO;
                timer_q <= timer_val;
            end
        end
    end
    assign misalign   = mis_q;
    assign resp_valid = resp_q;
    assign resp_rdata = resp_q ? load_extend(size_q, off_q, src_q == SRC_DMEM ? dmem_rdata
                                                          : src_q == SRC_TIMER ? timer_q : 32'h0)
                               : 32'h0;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized scoreboard bench for mem_lsu against a byte-level program-order memory model
module tb_mem_lsu;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] UART  = 32'hFFFF_0000;
    localparam logic [31:0] TIMER = 32'hFFFF_FF00;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_store = 1'b0;
    logic [2:0]  req_size = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, misalign, dmem_we, uart_valid;
    logic [31:0] resp_rdata, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [17:0] dmem_addr;
    logic [31:0] dmem_rdata = 32'h0;
    logic [7:0]  uart_data;
    logic        uart_ready = 1'b1;
    logic [31:0] timer_val = 32'h0;
    logic        acc_mis = 1'b0, mis_exp = 1'b0, rand_uart = 1'b0;
    int          checks = 0, failures = 0;
    logic [31:0] tb_mem [1024];
    logic [7:0]  ref_b [4096];
    logic [31:0] lq [$];
    logic [53:0] wq [$];
    logic [7:0]  uq [$];
    logic [2:0]  szs [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    mem_lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_store(req_store), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .misalign(misalign), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .uart_valid(uart_valid), .uart_data(uart_data), .uart_ready(uart_ready), .timer_val(timer_val)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dmem_we)
            tb_mem[dmem_addr[11:2]] <= (tb_mem[dmem_addr[11:2]] & ~{{8{dmem_be[3]}}, {8{dmem_be[2]}}, {8{dmem_be[1]}}, {8{dmem_be[0]}}})
                                     | (dmem_wdata & {{8{dmem_be[3]}}, {8{dmem_be[2]}}, {8{dmem_be[1]}}, {8{dmem_be[0]}}});
        dmem_rdata <= tb_mem[dmem_addr[11:2]];
        timer_val  <= timer_val + 32'd1;
        mis_exp    <= acc_mis;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [2:0] sz);
`ifdef LSU_MISALIGN_TRAP_EN
        return (a % nbytes(sz)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // architectural effect of an accepted request, in program order
    task automatic model_accept(input bit st, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int unsigned o, e;
        int          n;
        logic [3:0]  be;
        logic [31:0] d, v;
        o = a - BASE;
        n = nbytes(sz);
        be = 4'b0000;
        d = 32'h0;
        v = 32'h0;
        if (misaligned(a, sz)) begin
            acc_mis = 1'b1;
            return;
        end
        if (o < 2 ** 18) begin
            e = o - o % n;
            if (st) begin
                for (int i = 0; i < n; i++) begin
                    ref_b[e + i] = wd[8 * i +: 8];
                    be[(e + i) % 4] = 1'b1;
                    d[8 * ((e + i) % 4) +: 8] = wd[8 * i +: 8];
                end
                wq.push_back({18'(e - e % 4), be, d});
            end else begin
                check("load_cycle_no_write", dmem_we, 0);
                for (int i = 0; i < n; i++) v[8 * i +: 8] = ref_b[e + i];
                if (!sz[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
                lq.push_back(v);
            end
        end else if (st) begin
            if (a == UART) uq.push_back(wd[7:0]);
        end else begin
            lq.push_back(a == TIMER ? timer_val : 32'h0);
        end
    endtask

    task automatic issue(input bit st, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         output int stalls);
        stalls = 0;
        req_valid = 1'b1;
        req_store = st;
        req_size = sz;
        req_addr = a;
        req_wdata = wd;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            stalls++;
            if (stalls > 64) begin
                check("req_ready_timeout", req_ready, 1);
                break;
            end
        end
        if (stalls <= 64) model_accept(st, sz, a, wd);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc_mis = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                if (lq.size() != 0) check("resp_rdata", resp_rdata, lq.pop_front());
                else check("resp_unexpected", resp_valid, 0);
            end
            if (dmem_we) begin
                if (wq.size() != 0) check("dmem_write", {dmem_addr, dmem_be, dmem_wdata}, wq.pop_front());
                else check("write_unexpected", dmem_we, 0);
            end
            if (uart_valid) begin
                if (uq.size() != 0) check("uart_data", uart_data, uq.pop_front());
                else check("uart_unexpected", uart_valid, 0);
            end
            if (misalign || mis_exp) check("misalign", misalign, mis_exp);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_uart) uart_ready = $urandom_range(0, 3) != 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          s, r;
        logic [2:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0;
        for (int i = 0; i < 4096; i++) ref_b[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_misalign", misalign, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_dmem_be", dmem_be, 0);
        check("rst_dmem_addr", dmem_addr, 0);
        check("rst_dmem_wdata", dmem_wdata, 0);
        check("rst_uart_valid", uart_valid, 0);
        check("rst_uart_data", uart_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        // byte store lands in lane 3 on the next idle cycle
        issue(1'b1, 3'b000, BASE + 32'h3, 32'h0000_00AB, s);
        @(negedge clk);
        check("sb_drain_we", dmem_we, 1);
        check("sb_drain_be", dmem_be, 4'b1000);
        check("sb_drain_wdata", dmem_wdata, 32'hAB00_0000);
        @(posedge clk);
        #1;
        issue(1'b0, 3'b000, BASE + 32'h3, 32'h0, s);
        issue(1'b0, 3'b100, BASE + 32'h3, 32'h0, s);
        // store buffer under back-to-back store/load traffic
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 3'b010, BASE + 32'h20 + 32'(4 * i), $urandom, s);
            check("fill_store_ready", s, 0);
            issue(1'b0, 3'b010, BASE + 32'h40, 32'h0, s);
            check("fill_load_ready", s, 0);
        end
        issue(1'b1, 3'b010, BASE + 32'h30, $urandom, s);
        check("fifth_store_ready", s, 0);
        issue(1'b0, 3'b010, BASE + 32'h40, 32'h0, s);
        // load-after-store to the same word must wait for the drain
        issue(1'b1, 3'b010, BASE + 32'h10, 32'h1234_5678, s);
        issue(1'b0, 3'b010, BASE + 32'h10, 32'h0, s);
        check("hazard_stalled", s >= 1, 1);
        // UART back-pressure
        repeat (3) @(posedge clk);
        #1 uart_ready = 1'b0;
        fork
            begin
                repeat (3) @(posedge clk);
                #1 uart_ready = 1'b1;
            end
        join_none
        issue(1'b1, 3'b010, UART, 32'h0000_0041, s);
        check("uart_stall_cycles", s, 3);
        // halfword at odd address: trap or legacy aligned read
        issue(1'b1, 3'b010, BASE, 32'hCAFE_F00D, s);
        issue(1'b0, 3'b001, BASE + 32'h1, 32'h0, s);
        issue(1'b0, 3'b010, TIMER, 32'h0, s);
        issue(1'b0, 3'b010, BASE + 32'h0004_0000, 32'h0, s);
        // reset with one buffered store and one pending response
        issue(1'b1, 3'b010, BASE + 32'h200, $urandom, s);
        issue(1'b1, 3'b010, BASE + 32'h204, $urandom, s);
        issue(1'b0, 3'b010, BASE + 32'h40, 32'h0, s);
        rst = 1'b1;
        lq.delete();
        wq.delete();
        @(negedge clk);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_dmem_we", dmem_we, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_req_ready", req_ready, 1);
            check("postrst_dmem_we", dmem_we, 0);
        end
        @(posedge clk);
        #1 rand_uart = 1'b1;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            sz = szs[$urandom_range(0, 4)];
            a = BASE + $urandom_range(0, 127);
            if (r <= 3) issue(1'b1, sz, a, $urandom, s);
            else if (r <= 6) issue(1'b0, sz, a, 32'h0, s);
            else if (r == 7) begin
                case ($urandom_range(0, 3))
                    0: a = TIMER;
                    1: a = 32'h2000_0000 + $urandom_range(0, 255) * 4;
                    2: a = BASE + 32'h0004_0000;
                    default: a = BASE - 32'd4;
                endcase
                issue(1'b0, 3'b010, a, 32'h0, s);
            end else if (r == 8) begin
                a = $urandom_range(0, 1) ? UART : 32'h2000_0000 + $urandom_range(0, 255) * 4;
                issue(1'b1, 3'b000, a, $urandom, s);
            end else begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_uart = 1'b0;
        uart_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("resp_queue_drained", lq.size(), 0);
        check("write_queue_drained", wq.size(), 0);
        check("uart_queue_drained", uq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
